// File: rtl/lfa_pkg.sv
// Shared types for the LFA ADC scanner: FSM states, sensor slots and SPI frame sizes.
// Latency: none (types and constants only). Backpressure: not applicable.
// Used by the frame engine and by the scanner top level.
package lfa_pkg;

    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;
    localparam int PHASES     = 2 * FRAME_BITS;

    typedef enum logic [1:0] {S_GAP, S_XFER, S_DONE} state_t;
    typedef enum logic [1:0] {SLOT_L, SLOT_M, SLOT_R} slot_t;

    function automatic slot_t next_slot(input slot_t s);
        case (s)
            SLOT_L:  return SLOT_M;
            SLOT_M:  return SLOT_R;
            default: return SLOT_L;
        endcase
    endfunction

endpackage

// File: rtl/adc128_frame.sv
// Runs one 16-bit ADC128S022 SPI frame: 32 phases, sclk = phase[0], address on bits 2..4.
// Latency: cs_n low the clk after start for 32 clks; data is valid the clk after last.
// Backpressure: none; start is ignored while a frame is in flight.
module adc128_frame
    import lfa_pkg::*;
(
    input  logic                clk_3125KHz,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          addr,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic                adc_din,
    output logic [ADC_BITS-1:0] data,
    output logic                last
);

    localparam int PW = $clog2(PHASES);

    logic          active;
    logic [PW-1:0] p;
    logic [PW-1:0] p_nxt;
    logic [3:0]    b_nxt;
    logic [2:0]    addr_q;

    assign p_nxt = p + PW'(1);
    assign b_nxt = p_nxt[PW-1:1];
    assign last  = active && (p == PW'(PHASES - 1));

    function automatic logic din_bit(input logic [3:0] b, input logic [2:0] a);
        case (b)
            4'd2:    return a[2];
            4'd3:    return a[1];
            4'd4:    return a[0];
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            active   <= 1'b0;
            p        <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
            addr_q   <= '0;
            data     <= '0;
        end else if (start && !active) begin
            active   <= 1'b1;
            p        <= '0;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            adc_din  <= 1'b0;
            addr_q   <= addr;
        end else if (active) begin
            // dout is taken on the rising-sclk phase; bits 0..3 are leading zeros
            if (p[0] && (p[PW-1:1] >= 4'd4))
                data <= {data[ADC_BITS-2:0], adc_dout};
            if (last) begin
                active   <= 1'b0;
                p        <= '0;
                adc_cs_n <= 1'b1;
                adc_sclk <= 1'b1;
                adc_din  <= 1'b0;
            end else begin
                p        <= p_nxt;
                adc_sclk <= p_nxt[0];
                if (!p_nxt[0])
                    adc_din <= din_bit(b_nxt, addr_q);
            end
        end
    end

endmodule

// File: rtl/lfa_adc_scanner.sv
// Scans the left/middle/right LFA channels of an ADC128S022; optional LFA_AVG_EN smooths each output.
// Latency: GAP_CLKS+33 clks per frame; a full set (data_valid) every 3 frames after one prime frame.
// Backpressure: none; enable low finishes the current frame then parks in S_GAP.
module lfa_adc_scanner
    import lfa_pkg::*;
#(
    parameter logic [2:0] CH_LEFT   = 3'd3,
    parameter logic [2:0] CH_MIDDLE = 3'd2,
    parameter logic [2:0] CH_RIGHT  = 3'd1,
    parameter int         GAP_CLKS  = 2
)(
    input  logic                clk_3125KHz,
    input  logic                reset,
    input  logic                enable,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic                adc_din,
    output logic [ADC_BITS-1:0] left,
    output logic [ADC_BITS-1:0] middle,
    output logic [ADC_BITS-1:0] right,
    output logic                data_valid
);

    localparam int            GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

    state_t              state, state_nxt;
    slot_t               slot;
    logic                prime;
    logic [GW-1:0]       gap_cnt;
    logic                gap_done;
    logic                start;
    logic                frame_last;
    logic [2:0]          frame_addr;
    logic [ADC_BITS-1:0] sample;
    logic [ADC_BITS-1:0] new_word;

    function automatic logic [2:0] ch_addr(input slot_t s);
        case (s)
            SLOT_L:  return CH_LEFT;
            SLOT_M:  return CH_MIDDLE;
            default: return CH_RIGHT;
        endcase
    endfunction

    assign gap_done = (gap_cnt == GAP_LAST);
    assign start    = (state == S_GAP) && gap_done && enable;
    // The ADC answers one frame late, so each frame addresses the slot after the one being received
    assign frame_addr = prime ? CH_LEFT : ch_addr(next_slot(slot));

    adc128_frame u_frame (
        .clk_3125KHz (clk_3125KHz),
        .reset       (reset),
        .start       (start),
        .addr        (frame_addr),
        .adc_dout    (adc_dout),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_din     (adc_din),
        .data        (sample),
        .last        (frame_last)
    );

`ifdef LFA_AVG_EN
    logic [2:0]          loaded;
    logic [ADC_BITS-1:0] prev_word;
    logic [ADC_BITS:0]   sum;

    always_comb begin
        prev_word = right;
        case (slot)
            SLOT_L:  prev_word = left;
            SLOT_M:  prev_word = middle;
            default: prev_word = right;
        endcase
    end

    assign sum      = {1'b0, prev_word} + {1'b0, sample};
    assign new_word = loaded[slot] ? sum[ADC_BITS:1] : sample;

    always_ff @(posedge clk_3125KHz) begin
        if (reset)
            loaded <= '0;
        else if (state == S_DONE && !prime)
            loaded[slot] <= 1'b1;
    end
`else
    assign new_word = sample;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_GAP:   if (start) state_nxt = S_XFER;
            S_XFER:  if (frame_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_GAP;
            default: state_nxt = S_GAP;
        endcase
    end

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state      <= S_GAP;
            slot       <= SLOT_L;
            prime      <= 1'b1;
            gap_cnt    <= '0;
            left       <= '0;
            middle     <= '0;
            right      <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= 1'b0;
            case (state)
                S_GAP: begin
                    // Parking with enable low forces a fresh prime on restart
                    if (!enable)
                        prime <= 1'b1;
                    if (!gap_done)
                        gap_cnt <= gap_cnt + GW'(1);
                end
                S_DONE: begin
                    gap_cnt <= '0;
                    if (prime) begin
                        prime <= 1'b0;
                        slot  <= SLOT_L;
                    end else begin
                        case (slot)
                            SLOT_L:  left   <= new_word;
                            SLOT_M:  middle <= new_word;
                            default: begin
                                right      <= new_word;
                                data_valid <= 1'b1;
                            end
                        endcase
                        slot <= next_slot(slot);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
